// File: rtl/timing_ctrl.sv
// Basic-computer timing and control: start/stop flag, T0..T7 sequence counter,
// fetch strobes, register-reference execute and memory/IO hand-off wait.
module timing_ctrl #(
  parameter logic [2:0] RR_OPC = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        e_in,
  input  logic        ac_msb,
  input  logic        ac_lsb,
  input  logic        ac_zero,
  input  logic        mem_done,
  output logic [7:0]  t,
  output logic        ar_ld,
  output logic        ir_ld,
  output logic        mem_rd,
  output logic        pc_inc,
  output logic        e_en,
  output logic        e_clr,
  output logic        e_data,
  output logic        ac_clr,
  output logic        ac_cmp,
  output logic        ac_shr,
  output logic        ac_shl,
  output logic        ac_inc,
  output logic        mem_req,
  output logic        running
);

  localparam int unsigned SC_W = 3;
  localparam int unsigned T_W  = 8;

  // IDLE = S flag clear; RUN = S set, WAIT clear; WAIT = S set, WAIT set
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } mode_e;

  mode_e           mode_q, mode_d;
  logic [SC_W-1:0] sc_q, sc_d;

  logic is_rr;
  logic run_t0, run_t1, run_t2, run_t3;
  logic cle, cme, cir, cil, skip;

  assign is_rr  = ~ir[15] && (ir[14:12] == RR_OPC);

  assign run_t0 = (mode_q == ST_RUN) && (sc_q == SC_W'(0));
  assign run_t1 = (mode_q == ST_RUN) && (sc_q == SC_W'(1));
  assign run_t2 = (mode_q == ST_RUN) && (sc_q == SC_W'(2));
  assign run_t3 = (mode_q == ST_RUN) && (sc_q == SC_W'(3));

  assign cle  = ir[10];
  assign cme  = ir[8];
  assign cir  = ir[7];
  assign cil  = ir[6];
  assign skip = (ir[4] & ~ac_msb) | (ir[3] & ac_msb) | (ir[2] & ac_zero) | (ir[1] & ~e_in);

  // Next-state: sequence counter advance, WAIT entry/exit, start and halt
  always_comb begin
    mode_d = mode_q;
    sc_d   = sc_q;
    case (mode_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = ST_RUN;
          sc_d   = '0;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          mode_d = ST_RUN;
          sc_d   = '0;
        end
      end
      ST_RUN: begin
        case (sc_q)
          SC_W'(0), SC_W'(1): sc_d = sc_q + SC_W'(1);
          SC_W'(2): begin
            if (is_rr) sc_d   = SC_W'(3);
            else       mode_d = ST_WAIT;
          end
          SC_W'(3): begin
            sc_d = '0;
            if (ir[0]) mode_d = ST_IDLE;
          end
          default: sc_d = '0;
        endcase
      end
      default: begin
        mode_d = ST_IDLE;
        sc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= ST_IDLE;
      sc_q   <= '0;
    end else begin
      mode_q <= mode_d;
      sc_q   <= sc_d;
    end
  end

  // Strobes decode straight from state so each lands in its own timing step
  always_comb begin
    t       = '0;
    ar_ld   = 1'b0;
    ir_ld   = 1'b0;
    mem_rd  = 1'b0;
    pc_inc  = 1'b0;
    e_en    = 1'b0;
    e_clr   = 1'b0;
    e_data  = 1'b0;
    ac_clr  = 1'b0;
    ac_cmp  = 1'b0;
    ac_shr  = 1'b0;
    ac_shl  = 1'b0;
    ac_inc  = 1'b0;
    mem_req = (mode_q == ST_WAIT);
    running = (mode_q != ST_IDLE);

    if (mode_q == ST_RUN) t = T_W'(1) << sc_q;

    if (run_t0) ar_ld = 1'b1;

    if (run_t1) begin
      ir_ld  = 1'b1;
      mem_rd = 1'b1;
      pc_inc = 1'b1;
    end

    if (run_t3) begin
      ac_clr = ir[11];
      ac_cmp = ir[9];
      ac_shr = cir;
      ac_shl = cil;
      ac_inc = ir[5];
      pc_inc = skip;
      // E update priority: clear, complement, rotate right, rotate left
      if (cle) begin
        e_en  = 1'b1;
        e_clr = 1'b1;
      end else if (cme) begin
        e_en   = 1'b1;
        e_data = ~e_in;
      end else if (cir) begin
        e_en   = 1'b1;
        e_data = ac_lsb;
      end else if (cil) begin
        e_en   = 1'b1;
        e_data = ac_msb;
      end
    end
  end

endmodule

// File: tb/tb_timing_ctrl.sv
// Directed-vector bench for timing_ctrl: fetch sequence, register-reference
// execute, memory hand-off wait, halt and reset abort.
module tb_timing_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] ir;
  logic        e_in, ac_msb, ac_lsb, ac_zero, mem_done;
  logic [7:0]  t;
  logic        ar_ld, ir_ld, mem_rd, pc_inc;
  logic        e_en, e_clr, e_data;
  logic        ac_clr, ac_cmp, ac_shr, ac_shl, ac_inc;
  logic        mem_req, running;

  int n_vec  = 0;
  int n_miss = 0;

  // {ar_ld, ir_ld, mem_rd, pc_inc, e_en, e_clr, e_data, ac_clr, ac_cmp, ac_shr, ac_shl, ac_inc, mem_req}
  logic [12:0] strb;
  assign strb = {ar_ld, ir_ld, mem_rd, pc_inc, e_en, e_clr, e_data,
                 ac_clr, ac_cmp, ac_shr, ac_shl, ac_inc, mem_req};

  timing_ctrl #(.RR_OPC(3'b111)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ir       (ir),
    .e_in     (e_in),
    .ac_msb   (ac_msb),
    .ac_lsb   (ac_lsb),
    .ac_zero  (ac_zero),
    .mem_done (mem_done),
    .t        (t),
    .ar_ld    (ar_ld),
    .ir_ld    (ir_ld),
    .mem_rd   (mem_rd),
    .pc_inc   (pc_inc),
    .e_en     (e_en),
    .e_clr    (e_clr),
    .e_data   (e_data),
    .ac_clr   (ac_clr),
    .ac_cmp   (ac_cmp),
    .ac_shr   (ac_shr),
    .ac_shl   (ac_shl),
    .ac_inc   (ac_inc),
    .mem_req  (mem_req),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starting from T0: fetch, check T2 decision, then check the T3 strobes
  task automatic do_rr(input string tag, input logic [15:0] ir_v, input logic e_v,
                       input logic msb_v, input logic lsb_v, input logic zero_v,
                       input logic [12:0] exp_t3);
    ir      = ir_v;
    e_in    = e_v;
    ac_msb  = msb_v;
    ac_lsb  = lsb_v;
    ac_zero = zero_v;
    tick;
    tick;
    tick;
    check({tag, "_t3"}, 16'(t), 16'h0008);
    check({tag, "_strb"}, 16'(strb), 16'(exp_t3));
    tick;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ir = 16'h0000;
    e_in = 1'b0; ac_msb = 1'b0; ac_lsb = 1'b0; ac_zero = 1'b0; mem_done = 1'b0;
    #1;
    check("rst_t", 16'(t), 16'h0000);
    check("rst_running", 16'(running), 16'h0000);
    check("rst_strb", 16'(strb), 16'h0000);

    start = 1'b1;
    tick;
    tick;
    check("rst_start_ignored", 16'(running), 16'h0000);
    start = 1'b0;
    reset = 1'b0;
    tick;
    check("idle_after_release", 16'(running), 16'h0000);

    // First start: T0, T1, T2 then CLE execute
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_running", 16'(running), 16'h0001);
    check("t0_t", 16'(t), 16'h0001);
    check("t0_strb", 16'(strb), 16'h1000);
    ir = 16'h7400; e_in = 1'b1;
    tick;
    check("t1_t", 16'(t), 16'h0002);
    check("t1_strb", 16'(strb), 16'h0E00);
    tick;
    check("t2_t", 16'(t), 16'h0004);
    check("t2_strb", 16'(strb), 16'h0000);
    tick;
    check("cle_t3", 16'(t), 16'h0008);
    check("cle_strb", 16'(strb), 16'h0180);
    tick;
    check("cle_back_t0", 16'(t), 16'h0001);

    do_rr("cme",    16'h7100, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0140);
    do_rr("cir",    16'h7080, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0148);
    do_rr("cle_cme",16'h7500, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0180);
    do_rr("sze_e0", 16'h7002, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0200);
    do_rr("sze_e1", 16'h7002, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0000);
    do_rr("cil",    16'h7040, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0144);
    do_rr("cla_inc",16'h7820, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0022);
    do_rr("spa",    16'h7010, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0200);
    do_rr("sza_no", 16'h7004, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000);
    check("rr_loop_t0", 16'(t), 16'h0001);

    do_rr("hlt",    16'h7001, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000);
    check("hlt_running", 16'(running), 16'h0000);
    check("hlt_t", 16'(t), 16'h0000);
    tick;
    check("hlt_stays", 16'(running), 16'h0000);

    // Memory-reference: mem_done at T1 ignored, 5-cycle wait
    start = 1'b1;
    tick;
    start = 1'b0;
    check("restart_t0", 16'(t), 16'h0001);
    ir = 16'h2005;
    tick;
    mem_done = 1'b1;
    tick;
    mem_done = 1'b0;
    check("mem_t2_t", 16'(t), 16'h0004);
    check("mem_t2_strb", 16'(strb), 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      tick;
      check("wait_t", 16'(t), 16'h0000);
      check("wait_strb", 16'(strb), 16'h0001);
      if (i == 5) mem_done = 1'b1;
    end
    tick;
    mem_done = 1'b0;
    check("mem_done_t0", 16'(t), 16'h0001);
    check("mem_done_strb", 16'(strb), 16'h1000);

    // Reset in the middle of WAIT aborts immediately
    tick;
    tick;
    tick;
    check("wait2_req", 16'(mem_req), 16'h0001);
    #2 reset = 1'b1;
    #1;
    check("rst_wait_req", 16'(mem_req), 16'h0000);
    check("rst_wait_running", 16'(running), 16'h0000);
    check("rst_wait_t", 16'(t), 16'h0000);
    tick;
    reset = 1'b0;
    tick;
    tick;
    check("post_rst_idle", 16'(running), 16'h0000);
    check("post_rst_strb", 16'(strb), 16'h0000);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("resume_t0", 16'(t), 16'h0001);
    check("resume_running", 16'(running), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/timing_ctrl.md
TIMING_CTRL -- requirements
Module: timing_ctrl

Interface
REQ-001 Parameter: RR_OPC, default 3'b111, ir[14:12] value identifying register-reference instructions (with ir[15]=0).
REQ-002 clk  in  1  sole clock; all state changes on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  in  1  request to set the start-stop (S) flag.
REQ-005 ir  in  16  instruction register contents; valid from T2 onward.
REQ-006 e_in  in  1  current E flip-flop value.
REQ-007 ac_msb / ac_lsb / ac_zero  in  1 each  accumulator bit 15, bit 0, AC==0.
REQ-008 mem_done  in  1  completion pulse from memory/IO executor.
REQ-009 t  out  8  one-hot timing signals T0..T7; all zero when not running.
REQ-010 ar_ld, ir_ld, mem_rd, pc_inc  out  1 each  fetch-phase strobes.
REQ-011 e_en, e_clr, e_data  out  1 each  E flip-flop enable, clear, next data.
REQ-012 ac_clr, ac_cmp, ac_shr, ac_shl, ac_inc  out  1 each  accumulator op strobes.
REQ-013 mem_req  out  1  hand-off request for non-register-reference instructions.
REQ-014 running  out  1  S flag value.

Function
REQ-015 State: S flag, 3-bit sequence counter SC, WAIT flag; t = one-hot(SC) when S=1 and WAIT=0, else 8'h00.
REQ-016 Start: start=1 with S=0 sets S and SC=0 at next edge; T0 in following cycle; start while S=1 ignored.
REQ-017 T0: ar_ld=1; SC increments.
REQ-018 T1: ir_ld=1, mem_rd=1, pc_inc=1; SC increments.
REQ-019 T2: if ir[15]=0 and ir[14:12]=RR_OPC, SC increments to T3; otherwise WAIT set, SC held.
REQ-020 WAIT: mem_req=1, t=0 every cycle; edge with mem_done=1 clears WAIT and SC=0 (T0 next cycle); no timeout.
REQ-021 mem_done outside WAIT ignored.
REQ-022 T3 (register-reference execute, single cycle), all set bits act concurrently: ir[11] ac_clr; ir[10] CLE; ir[9] ac_cmp; ir[8] CME; ir[7] ac_shr+CIR; ir[6] ac_shl+CIL; ir[5] ac_inc.
REQ-023 E control at T3: CLE -> e_en=1, e_clr=1, e_data=0; else CME -> e_en=1, e_data=~e_in; else CIR -> e_en=1, e_data=ac_lsb; else CIL -> e_en=1, e_data=ac_msb; none -> e_en=0, e_clr=0.
REQ-024 Skip at T3: pc_inc=1 if (ir[4]&~ac_msb)|(ir[3]&ac_msb)|(ir[2]&ac_zero)|(ir[1]&~e_in).
REQ-025 Halt: ir[0] at T3 clears S at end of T3; other T3 strobes still issued that cycle.
REQ-026 End of T3 without halt: SC=0, T0 next cycle; T4..T7 never reached in this revision.
REQ-027 All strobes combinational from SC/WAIT/S/ir and zero in any cycle not listed above.
REQ-028 Strobes asserted for exactly one cycle per timing step.

Reset
REQ-029 Reset asserted: S=0, SC=0, WAIT=0 asynchronously; t=0, mem_req=0, running=0, all strobes 0 while reset high.
REQ-030 Reset mid-fetch, mid-WAIT or at T3 aborts the instruction; no strobe in the reset cycle; resume only via start.
REQ-031 start during reset ignored; first start after reset release behaves per REQ-016.

Verification
REQ-032 Reset release, start pulse -> running=1 next edge; t sequence 01,02,04 with ar_ld@T0, ir_ld/mem_rd/pc_inc@T1.
REQ-033 ir=16'h7400 (CLE), e_in=1 -> at T3 e_en=1, e_clr=1, e_data=0; t=01 next cycle.
REQ-034 ir=16'h7100 (CME), e_in=0 -> e_data=1; ir=16'h7080 (CIR), ac_lsb=1 -> e_data=1, ac_shr=1; ir=16'h7500 -> e_clr wins.
REQ-035 ir=16'h7002 (SZE), e_in=0 -> pc_inc=1 at T3; e_in=1 -> pc_inc=0 at T3.
REQ-036 ir=16'h2005 -> mem_req high from cycle after T2 for 5 cycles; mem_done on 5th -> t=01 next cycle; mem_done at T1 ignored.
REQ-037 ir=16'h7001 (HLT) -> running=0, t=00 after T3; reset asserted mid-WAIT -> mem_req=0 immediately, start needed to resume.
